nco_phase_accum: RTL
====================

Name: nco_phase_accum

Overview:
- Phase-accumulator stage directly downstream of the step/phase controller.
- Consumes the signed step word, the same width as the controller's o_step. On every sample tick it adds the step to a modulo-2^PHASE_W phase register.
- Folds the phase into a quarter-wave LUT address plus a sign flag, with a one-cycle valid strobe.
- Feeds the sine LUT / DAC output path of the FPGA DSP lab design.

Parameters:
- SIZE_STEP, 7, step MSB index; step width is SIZE_STEP+1 bits, two's complement.
- PHASE_W, 12, phase accumulator width in bits; must be >= ADDR_W+2.
- ADDR_W, 8, quarter-wave LUT address width.
- TICK_DIV, 50, i_clk cycles per sample tick; must be >= 2.

Ports:
- i_clk  input  1  system clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_en  input  1  run enable; when low, tick counter and phase hold.
- i_step  input  SIZE_STEP+1  signed phase increment, sampled only on tick cycles.
- o_phase  output  PHASE_W  current accumulated phase, unsigned.
- o_addr  output  ADDR_W  folded quarter-wave LUT address.
- o_neg  output  1  output-sample sign (1 = negative half-wave).
- o_valid  output  1  one-cycle pulse: o_addr/o_neg updated.
- o_wrap  output  1  one-cycle pulse: phase wrapped (carry or borrow).

Behaviour:
- Reset (async, i_rst_n low): tick counter, phase, o_addr, o_neg, o_valid and o_wrap all 0. Release is synchronous to the next i_clk edge.
- Tick counter:
  - Counts 0..TICK_DIV-1 while i_en = 1; wraps to 0.
  - tick = i_en & (cnt == TICK_DIV-1).
  - i_en = 0 freezes cnt. No tick is generated while disabled.
- Stage 1, on the tick cycle T:
  - phase <= phase + sign_extend(i_step), modulo 2^PHASE_W.
  - o_phase is visible at T+1.
  - o_wrap = 1 for exactly cycle T+1 if the add produced a carry out (step > 0) or a borrow (step < 0). Otherwise 0.
  - i_step changes between ticks have no effect.
  - step = 0 leaves phase unchanged but still produces a valid strobe.
- Stage 2, registered from the stage-1 result:
  - q = phase[PHASE_W-1:PHASE_W-2]; idx = phase[PHASE_W-3:PHASE_W-2-ADDR_W]; lower bits are dropped.
  - o_addr = q[0] ? ~idx : idx (mirrors index in quadrants 1 and 3).
  - o_neg = q[1].
  - o_valid = 1 for exactly cycle T+2. o_addr/o_neg hold their values between strobes.
- Latency: tick at T -> o_phase/o_wrap at T+1 -> o_addr/o_neg/o_valid at T+2.
- Throughput: one sample per TICK_DIV cycles. The pipeline never overlaps because TICK_DIV >= 2.
- i_en falling at T+1 after a tick at T: stage 2 still completes and o_valid pulses at T+2.
- Reset mid-operation: everything clears immediately. The first post-reset tick occurs TICK_DIV enabled cycles after release.
- Extreme steps (-2^SIZE_STEP, 2^SIZE_STEP-1): sign extension is correct and wrap is detected correctly.

Decomposition:
- Shared package (dsp_pkg): phase/address width constants, a typedef for the signed step word (shared with the step controller), and a quadrant enum Q0..Q3.
- One natural sub-module: tick_prescaler (parameter TICK_DIV; ports i_clk, i_rst_n, i_en, o_tick). It is reusable by other sample-rate stages.
- Accumulate and fold stages stay inline.

Test Plan (TICK_DIV=4, PHASE_W=12, ADDR_W=8, SIZE_STEP=7):
- Reset then i_en=1, i_step=+1 for 5 ticks:
  - o_phase steps 1,2,3,4,5, spaced 4 cycles apart.
  - o_valid pulses 2 cycles after each tick.
  - o_wrap stays 0.
- From reset, i_step=-1, one tick:
  - o_phase=0xFFF and o_wrap=1 at T+1.
  - At T+2: o_addr=0x00, o_neg=1, o_valid=1.
- i_step=+63 for 17 ticks:
  - o_phase=0x42F.
  - q=01, idx=0x0B, so o_addr=0xF4, o_neg=0.
- i_step toggled between +1 and -1 every cycle except on tick cycles, where it is held at +3: phase advances by exactly 3 per tick.
- i_en low for 10 cycles mid-count:
  - o_phase, o_valid and the tick spacing are frozen.
  - Resuming completes the remaining count before the next tick.
- i_rst_n asserted in the cycle after a tick:
  - All outputs are 0 immediately and no o_valid pulse follows.
  - First post-release update occurs after 4 enabled cycles.

Source files
------------

// File: rtl/dsp_pkg.sv
// Shared DSP-path definitions for the NCO chain.
// - Default widths for the phase accumulator, LUT address and step word.
// - step_t: signed step word exchanged between the step/phase controller and
//   the phase accumulator.
// - quad_e: quadrant of the phase circle, taken from the two phase MSBs.
package dsp_pkg;

  localparam int unsigned STEP_MSB_DEF = 7;
  localparam int unsigned PHASE_W_DEF  = 12;
  localparam int unsigned ADDR_W_DEF   = 8;
  localparam int unsigned TICK_DIV_DEF = 50;

  typedef logic signed [STEP_MSB_DEF:0] step_t;

  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quad_e;

endpackage

// File: rtl/tick_prescaler.sv
// Sample-tick prescaler: divides i_clk down to a one-cycle tick every
// TICK_DIV enabled cycles. Reusable by any sample-rate stage.
// Ports:
//   i_clk   - system clock, rising edge
//   i_rst_n - asynchronous active-low reset (counter cleared)
//   i_en    - count enable; when low the counter holds and no tick is issued
//   o_tick  - high during the last enabled cycle of each TICK_DIV period
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 50
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  output logic o_tick
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic             at_max;

  always_comb begin
    at_max = (cnt == CNT_MAX);
    o_tick = i_en & at_max;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt <= '0;
    end else if (i_en) begin
      cnt <= at_max ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/nco_phase_accum.sv
// NCO phase accumulator with quarter-wave fold.
// Each sample tick adds the signed step to a modulo-2^PHASE_W phase register
// (stage 1), then folds the phase into a quarter-wave LUT address plus a
// sign flag (stage 2).
// Ports:
//   i_clk   - system clock, rising edge
//   i_rst_n - asynchronous active-low reset
//   i_en    - run enable; tick counter and phase hold while low
//   i_step  - signed phase increment, sampled only on tick cycles
//   o_phase - accumulated phase (unsigned)
//   o_addr  - folded quarter-wave LUT address
//   o_neg   - sample sign, 1 = negative half-wave
//   o_valid - one-cycle pulse when o_addr/o_neg update
//   o_wrap  - one-cycle pulse when the phase add carried or borrowed
// Latency: tick at T -> o_phase/o_wrap at T+1 -> o_addr/o_neg/o_valid at T+2.
module nco_phase_accum
  import dsp_pkg::*;
#(
  parameter int unsigned SIZE_STEP = STEP_MSB_DEF,
  parameter int unsigned PHASE_W   = PHASE_W_DEF,
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned TICK_DIV  = TICK_DIV_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic signed [SIZE_STEP:0] i_step,
  output logic [PHASE_W-1:0]    o_phase,
  output logic [ADDR_W-1:0]     o_addr,
  output logic                  o_neg,
  output logic                  o_valid,
  output logic                  o_wrap
);

  logic tick;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_prescaler (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (i_en),
    .o_tick  (tick)
  );

  // ---------------- stage 1: accumulate ----------------
  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] step_ext;
  logic [PHASE_W-1:0] phase_sum;
  logic               wrap_nxt;
  logic               stage1_vld;

  // A positive step wrapped iff the modulo sum fell below the old phase;
  // a negative step wrapped (borrow) iff the sum rose above it.
  always_comb begin
    step_ext  = {{(PHASE_W - SIZE_STEP - 1){i_step[SIZE_STEP]}}, i_step};
    phase_sum = phase + step_ext;
    wrap_nxt  = i_step[SIZE_STEP] ? (phase_sum > phase) : (phase_sum < phase);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      phase      <= '0;
      o_wrap     <= 1'b0;
      stage1_vld <= 1'b0;
    end else begin
      stage1_vld <= tick;
      o_wrap     <= tick & wrap_nxt;
      if (tick) begin
        phase <= phase_sum;
      end
    end
  end

  assign o_phase = phase;

  // ---------------- stage 2: quarter-wave fold ----------------
  quad_e             quad;
  logic [ADDR_W-1:0] idx;

  // Quadrants 1 and 3 run the quarter-wave table backwards;
  // quadrants 2 and 3 are the negative half-wave.
  always_comb begin
    quad = quad_e'(phase[PHASE_W-1 -: 2]);
    idx  = phase[PHASE_W-3 -: ADDR_W];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_addr  <= '0;
      o_neg   <= 1'b0;
      o_valid <= 1'b0;
    end else begin
      o_valid <= stage1_vld;
      if (stage1_vld) begin
        o_addr <= (quad == Q1 || quad == Q3) ? ~idx : idx;
        o_neg  <= (quad == Q2 || quad == Q3);
      end
    end
  end

endmodule
